// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - density encodings and default timing/threshold constants shared with the light controller
package traffic_pkg;

  typedef enum logic [1:0] {
    DENS_LOW  = 2'b00,
    DENS_MED  = 2'b01,
    DENS_HIGH = 2'b10
  } dens_t;

  localparam int DEBOUNCE_CYC_DEF  = 4;
  localparam int DISCHARGE_CYC_DEF = 2;
  localparam int QW_DEF            = 6;
  localparam int QMAX_DEF          = 63;
  localparam int TH_MED_DEF        = 4;
  localparam int TH_HIGH_DEF       = 12;

  function automatic dens_t dens_encode(input int q, input int th_med, input int th_high);
    if (q >= th_high) return DENS_HIGH;
    if (q >= th_med)  return DENS_MED;
    return DENS_LOW;
  endfunction

endpackage

// File: rtl/traffic_lane_counter.sv
// rtl/traffic_lane_counter.sv - one road: detector sync/debounce, arrival edge, green discharge, queue and level
module traffic_lane_counter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int DISCHARGE_CYC = DISCHARGE_CYC_DEF,
  parameter int QW            = QW_DEF,
  parameter int QMAX          = QMAX_DEF,
  parameter int TH_MED        = TH_MED_DEF,
  parameter int TH_HIGH       = TH_HIGH_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          det,
  input  logic          green,
  output logic [1:0]    traffic,
  output logic [QW-1:0] queue
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW = $clog2(DISCHARGE_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [PW-1:0] DIS_LAST = PW'(DISCHARGE_CYC - 1);
  localparam logic [QW-1:0] QSAT     = QW'(QMAX);

  logic          sync1;
  logic          s;
  logic          d;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic          arrival;
  logic          departure;

  // Arrival fires in the same cycle d is accepted high, so the queue moves on that edge.
  assign arrival   = s && !d && (dcnt == DEB_LAST);
  assign departure = green && (pcnt == DIS_LAST) && (queue != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      d       <= 1'b0;
      dcnt    <= '0;
      pcnt    <= '0;
      queue   <= '0;
      traffic <= DENS_LOW;
    end else begin
      sync1 <= det;
      s     <= sync1;

      if (s == d) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        d    <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end

      if (!green || pcnt == DIS_LAST) pcnt <= '0;
      else                            pcnt <= pcnt + 1'b1;

      if (arrival && !departure) begin
        if (queue != QSAT) queue <= queue + 1'b1;
      end else if (departure && !arrival) begin
        queue <= queue - 1'b1;
      end

      traffic <= dens_encode(int'(queue), TH_MED, TH_HIGH);
    end
  end

endmodule

// File: rtl/traffic_density_sensor.sv
// rtl/traffic_density_sensor.sv - three identical road lane counters feeding the adaptive light controller
module traffic_density_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int DISCHARGE_CYC = DISCHARGE_CYC_DEF,
  parameter int QW            = QW_DEF,
  parameter int QMAX          = QMAX_DEF,
  parameter int TH_MED        = TH_MED_DEF,
  parameter int TH_HIGH       = TH_HIGH_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          det_A,
  input  logic          det_B,
  input  logic          det_C,
  input  logic          A_green,
  input  logic          B_green,
  input  logic          C_green,
  output logic [1:0]    traffic_A,
  output logic [1:0]    traffic_B,
  output logic [1:0]    traffic_C,
  output logic [QW-1:0] queue_A,
  output logic [QW-1:0] queue_B,
  output logic [QW-1:0] queue_C
);

  traffic_lane_counter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .DISCHARGE_CYC(DISCHARGE_CYC), .QW(QW),
    .QMAX(QMAX), .TH_MED(TH_MED), .TH_HIGH(TH_HIGH)
  ) u_lane_a (
    .clk(clk), .reset_n(reset_n), .det(det_A), .green(A_green),
    .traffic(traffic_A), .queue(queue_A)
  );

  traffic_lane_counter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .DISCHARGE_CYC(DISCHARGE_CYC), .QW(QW),
    .QMAX(QMAX), .TH_MED(TH_MED), .TH_HIGH(TH_HIGH)
  ) u_lane_b (
    .clk(clk), .reset_n(reset_n), .det(det_B), .green(B_green),
    .traffic(traffic_B), .queue(queue_B)
  );

  traffic_lane_counter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .DISCHARGE_CYC(DISCHARGE_CYC), .QW(QW),
    .QMAX(QMAX), .TH_MED(TH_MED), .TH_HIGH(TH_HIGH)
  ) u_lane_c (
    .clk(clk), .reset_n(reset_n), .det(det_C), .green(C_green),
    .traffic(traffic_C), .queue(queue_C)
  );

endmodule

// File: tb/tb_traffic_density_sensor.sv
// tb/tb_traffic_density_sensor.sv - scoreboard bench: stimulus queues edge-stamped expectations, negedge monitor checks them
module tb_traffic_density_sensor;

  localparam int Q_A = 0, Q_B = 1, Q_C = 2, T_A = 3, T_B = 4, T_C = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] det;
  logic [2:0] green;
  logic [1:0] traffic_A, traffic_B, traffic_C;
  logic [5:0] queue_A, queue_B, queue_C;

  typedef struct {
    int due;
    int sel;
    int val;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   tests    = 0;
  int   failed   = 0;
  int   e0, dstart, gstart;

  traffic_density_sensor dut (
    .clk(clk), .reset_n(reset_n),
    .det_A(det[0]), .det_B(det[1]), .det_C(det[2]),
    .A_green(green[0]), .B_green(green[1]), .C_green(green[2]),
    .traffic_A(traffic_A), .traffic_B(traffic_B), .traffic_C(traffic_C),
    .queue_A(queue_A), .queue_B(queue_B), .queue_C(queue_C)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int field(input int sel);
    case (sel)
      Q_A: return int'(queue_A);
      Q_B: return int'(queue_B);
      Q_C: return int'(queue_C);
      T_A: return int'(traffic_A);
      T_B: return int'(traffic_B);
      T_C: return int'(traffic_C);
      default: return -1;
    endcase
  endfunction

  function automatic string fname(input int sel);
    case (sel)
      Q_A: return "queue_A";
      Q_B: return "queue_B";
      Q_C: return "queue_C";
      T_A: return "traffic_A";
      T_B: return "traffic_B";
      T_C: return "traffic_C";
      default: return "unknown";
    endcase
  endfunction

  // Hand model of the level thresholds (4 / 12).
  function automatic int exp_level(input int q);
    if (q >= 12) return 2;
    if (q >= 4)  return 1;
    return 0;
  endfunction

  function automatic int sat63(input int q);
    return (q > 63) ? 63 : q;
  endfunction

  task automatic push_exp(input int due, input int sel, input int val);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vehicle(input int road, input int hi, input int lo);
    det[road] = 1'b1;
    tick(hi);
    det[road] = 1'b0;
    tick(lo);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == edge_cnt) begin
        tests++;
        if (field(sb[i].sel) != sb[i].val) begin
          failed++;
          $display("FAIL %s at edge %0d: got %0d, expected %0d",
                   fname(sb[i].sel), edge_cnt, field(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].due < edge_cnt) begin
        tests++;
        failed++;
        $display("FAIL stale_%s due edge %0d: got never, expected %0d",
                 fname(sb[i].sel), sb[i].due, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    det     = 3'b000;
    green   = 3'b000;

    // Reset held with det_A toggling: everything stays cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      det[0] = ~det[0];
      for (int s = 0; s < 6; s++) push_exp(edge_cnt + 1, s, 0);
    end

    @(negedge clk);
    e0 = edge_cnt;
    reset_n = 1'b1;
    det[0]  = 1'b1;
    push_exp(e0 + 5, Q_A, 0);
    push_exp(e0 + 6, Q_A, 1);
    push_exp(e0 + 6, T_A, 0);
    push_exp(e0 + 7, T_A, 0);
    tick(8);
    det[0] = 1'b0;
    tick(10);

    // Debounce: 3-cycle glitches on B are rejected, a 10-cycle high counts once.
    e0 = edge_cnt;
    for (int k = 1; k <= 40; k++) push_exp(e0 + k, Q_B, 0);
    repeat (5) begin
      det[1] = 1'b1;
      tick(3);
      det[1] = 1'b0;
      tick(4);
    end
    e0 = edge_cnt;
    push_exp(e0 + 5, Q_B, 0);
    for (int k = 6; k <= 20; k++) push_exp(e0 + k, Q_B, 1);
    det[1] = 1'b1;
    tick(10);
    det[1] = 1'b0;
    tick(12);

    // Thresholds on C: 12 clean vehicles.
    for (int i = 0; i < 12; i++) begin
      e0 = edge_cnt;
      push_exp(e0 + 5, Q_C, i);
      push_exp(e0 + 6, Q_C, i + 1);
      push_exp(e0 + 6, T_C, exp_level(i));
      push_exp(e0 + 7, T_C, exp_level(i + 1));
      vehicle(2, 8, 8);
    end

    // Discharge on A: bring queue to 5, 1-cycle green pulse, then 10-cycle green.
    for (int i = 0; i < 4; i++) begin
      e0 = edge_cnt;
      push_exp(e0 + 6, Q_A, 2 + i);
      vehicle(0, 8, 8);
    end
    tick(2);
    e0 = edge_cnt;
    for (int k = 1; k <= 5; k++) push_exp(e0 + k, Q_A, 5);
    green[0] = 1'b1;
    tick(1);
    green[0] = 1'b0;
    tick(5);
    e0 = edge_cnt;
    for (int k = 1; k <= 12; k++) push_exp(e0 + k, Q_A, (k <= 10) ? 5 - k / 2 : 0);
    push_exp(e0 + 4, T_A, 1);
    push_exp(e0 + 5, T_A, 0);
    push_exp(e0 + 12, T_A, 0);
    green[0] = 1'b1;
    tick(10);
    green[0] = 1'b0;
    tick(4);

    // Simultaneous arrival and departure on B.
    for (int i = 0; i < 2; i++) begin
      e0 = edge_cnt;
      push_exp(e0 + 6, Q_B, 2 + i);
      vehicle(1, 8, 8);
    end
    dstart = edge_cnt;
    det[1] = 1'b1;
    tick(4);
    gstart = edge_cnt;
    for (int k = 1; k <= 3; k++) push_exp(gstart + k, Q_B, 3);
    for (int k = 4; k <= 6; k++) push_exp(gstart + k, Q_B, 2);
    green[1] = 1'b1;
    tick(4);
    green[1] = 1'b0;
    tick(4);
    det[1] = 1'b0;
    tick(10);

    // Saturation on A, then asynchronous reset mid-vehicle.
    for (int i = 0; i < 70; i++) begin
      e0 = edge_cnt;
      push_exp(e0 + 6, Q_A, sat63(i + 1));
      push_exp(e0 + 7, T_A, exp_level(sat63(i + 1)));
      vehicle(0, 8, 8);
    end
    det[0] = 1'b1;
    tick(3);
    e0 = edge_cnt;
    push_exp(e0 + 1, Q_A, 0);
    push_exp(e0 + 1, T_A, 0);
    push_exp(e0 + 1, Q_C, 0);
    push_exp(e0 + 1, T_C, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    det     = 3'b000;
    tick(3);

    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
